// File: rtl/game_sequencer.sv
// game_sequencer: play controller for the meteor field.
// Owns the IDLE/RUN/PAUSE/OVER state, generates the game_enable tick whose
// period shrinks with the difficulty level, scores dodged meteors and
// handles hits. clear_meteors re-arms the meteor field.
// Optional feature: define GAME_SEQUENCER_LIVES_EN to enable multiple lives
// (otherwise every hit ends the game and lives_o stays 0).
module game_sequencer #(
    parameter int unsigned TICK_DIV_BASE = 833333,
    parameter int unsigned TICK_DIV_STEP = 83333,
    parameter int unsigned LEVEL_UP      = 10,
    parameter int unsigned MAX_LEVEL     = 7,
    parameter int unsigned START_LIVES   = 3
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_btn_i,
    input  logic        pause_btn_i,
    input  logic        hit_i,
    input  logic        meteor_passed_i,
    output logic        game_enable_o,
    output logic        clear_meteors_o,
    output logic [1:0]  state_o,
    output logic [15:0] score_o,
    output logic [2:0]  level_o,
    output logic [1:0]  lives_o
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StOver  = 2'd3
    } state_e;

    localparam logic [19:0] BaseW     = 20'(TICK_DIV_BASE);
    localparam logic [19:0] StepW     = 20'(TICK_DIV_STEP);
    localparam logic [7:0]  LevelUpW  = 8'(LEVEL_UP);
    localparam logic [2:0]  MaxLevelW = 3'(MAX_LEVEL);
`ifdef GAME_SEQUENCER_LIVES_EN
    localparam logic [1:0]  StartLivesW = 2'(START_LIVES);
`else
    localparam logic [1:0]  StartLivesW = 2'd0;
    logic unused_start_lives;
    assign unused_start_lives = ^START_LIVES;
`endif

    state_e      state_q, state_d;
    logic        start_q, pause_q;
    logic [19:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]  pass_cnt_q, pass_cnt_d;
    logic [15:0] score_q, score_d;
    logic [2:0]  level_q, level_d;
    logic [1:0]  lives_q, lives_d;
    logic        game_enable_q, game_enable_d;
    logic        clear_q, clear_d;

    logic        start_edge, pause_edge;
    logic [19:0] period_m1;
    logic        tick_due;

    // Rising-edge detection on the level buttons.
    always_comb begin
        start_edge = start_btn_i & ~start_q;
        pause_edge = pause_btn_i & ~pause_q;
    end

    // Terminal count follows the current level; >= lets a level-up that
    // shortens the period below the running count fire right away.
    always_comb begin
        period_m1 = BaseW - (StepW * {17'd0, level_q}) - 20'd1;
        tick_due  = (tick_cnt_q >= period_m1);
    end

    // Next-state and datapath updates for the play controller.
    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        pass_cnt_d    = pass_cnt_q;
        score_d       = score_q;
        level_d       = level_q;
        lives_d       = lives_q;
        game_enable_d = 1'b0;
        clear_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_edge) begin
                    state_d    = StRun;
                    score_d    = 16'd0;
                    level_d    = 3'd0;
                    pass_cnt_d = 8'd0;
                    tick_cnt_d = 20'd0;
                    lives_d    = StartLivesW;
                    clear_d    = 1'b1;
                end
            end

            StRun: begin
                if (tick_due) begin
                    tick_cnt_d    = 20'd0;
                    game_enable_d = 1'b1;
                end else begin
                    tick_cnt_d = tick_cnt_q + 20'd1;
                end

                if (meteor_passed_i) begin
                    if (score_q != 16'hFFFF) begin
                        score_d = score_q + 16'd1;
                    end
                    if ((pass_cnt_q + 8'd1) == LevelUpW) begin
                        pass_cnt_d = 8'd0;
                        if (level_q < MaxLevelW) begin
                            level_d = level_q + 3'd1;
                        end
                    end else begin
                        pass_cnt_d = pass_cnt_q + 8'd1;
                    end
                end

                // A hit takes priority over a pause edge in the same cycle.
                if (hit_i) begin
                    game_enable_d = 1'b0;
`ifdef GAME_SEQUENCER_LIVES_EN
                    if (lives_q > 2'd1) begin
                        lives_d    = lives_q - 2'd1;
                        clear_d    = 1'b1;
                        tick_cnt_d = 20'd0;
                    end else begin
                        lives_d = 2'd0;
                        state_d = StOver;
                    end
`else
                    state_d = StOver;
`endif
                end else if (pause_edge) begin
                    state_d       = StPause;
                    tick_cnt_d    = tick_cnt_q;
                    game_enable_d = 1'b0;
                end
            end

            StPause: begin
                if (pause_edge) begin
                    state_d = StRun;
                end
            end

            StOver: begin
                if (start_edge) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            start_q       <= 1'b0;
            pause_q       <= 1'b0;
            tick_cnt_q    <= 20'd0;
            pass_cnt_q    <= 8'd0;
            score_q       <= 16'd0;
            level_q       <= 3'd0;
            lives_q       <= StartLivesW;
            game_enable_q <= 1'b0;
            clear_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_btn_i;
            pause_q       <= pause_btn_i;
            tick_cnt_q    <= tick_cnt_d;
            pass_cnt_q    <= pass_cnt_d;
            score_q       <= score_d;
            level_q       <= level_d;
            lives_q       <= lives_d;
            game_enable_q <= game_enable_d;
            clear_q       <= clear_d;
        end
    end

    assign game_enable_o   = game_enable_q;
    assign clear_meteors_o = clear_q;
    assign state_o         = state_q;
    assign score_o         = score_q;
    assign level_o         = level_q;
    assign lives_o         = lives_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed testbench for game_sequencer (BASE=10 STEP=1 LEVEL_UP=2 MAX_LEVEL=3).
module tb_game_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_btn = 1'b0;
    logic        pause_btn = 1'b0;
    logic        hit = 1'b0;
    logic        meteor_passed = 1'b0;
    logic        game_enable;
    logic        clear_meteors;
    logic [1:0]  state;
    logic [15:0] score;
    logic [2:0]  level;
    logic [1:0]  lives;

    int n_cmp = 0;
    int n_err = 0;

`ifdef GAME_SEQUENCER_LIVES_EN
    localparam logic [1:0] RstLives = 2'd3;
`else
    localparam logic [1:0] RstLives = 2'd0;
`endif

    always #5 clk = ~clk;

    game_sequencer #(
        .TICK_DIV_BASE(10),
        .TICK_DIV_STEP(1),
        .LEVEL_UP     (2),
        .MAX_LEVEL    (3),
        .START_LIVES  (3)
    ) u_dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .start_btn_i    (start_btn),
        .pause_btn_i    (pause_btn),
        .hit_i          (hit),
        .meteor_passed_i(meteor_passed),
        .game_enable_o  (game_enable),
        .clear_meteors_o(clear_meteors),
        .state_o        (state),
        .score_o        (score),
        .level_o        (level),
        .lives_o        (lives)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset then start: returns one cycle after RUN entry (tick_cnt = 1).
    task automatic restart();
        hit = 1'b0; meteor_passed = 1'b0; pause_btn = 1'b0; start_btn = 1'b0;
        reset = 1'b1; tick();
        reset = 1'b0; start_btn = 1'b1; tick();
        start_btn = 1'b0; tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(); tick();
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++; if (game_enable !== 1'b0) begin n_err++; $display("FAIL reset_ge: got %b want 0", game_enable); end
        n_cmp++; if (clear_meteors !== 1'b0) begin n_err++; $display("FAIL reset_clr: got %b want 0", clear_meteors); end
        n_cmp++; if (score !== 16'd0) begin n_err++; $display("FAIL reset_score: got %0d want 0", score); end
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
        n_cmp++; if (lives !== RstLives) begin n_err++; $display("FAIL reset_lives: got %0d want %0d", lives, RstLives); end
        reset = 1'b0; tick();
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL idle_stays: got %0d want 0", state); end
    endtask

    task automatic test_start_ticks();
        logic exp_ge;
        start_btn = 1'b1; tick();
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL start_state: got %0d want 1", state); end
        n_cmp++; if (clear_meteors !== 1'b1) begin n_err++; $display("FAIL start_clr: got %b want 1", clear_meteors); end
        n_cmp++; if (game_enable !== 1'b0) begin n_err++; $display("FAIL start_ge: got %b want 0", game_enable); end
        start_btn = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            exp_ge = ((i % 10) == 0);
            n_cmp++; if (game_enable !== exp_ge) begin n_err++; $display("FAIL tick10_c%0d: got %b want %b", i, game_enable, exp_ge); end
            n_cmp++; if (clear_meteors !== 1'b0) begin n_err++; $display("FAIL tick10_clr_c%0d: got %b want 0", i, clear_meteors); end
        end
    endtask

    task automatic test_levels();
        logic exp_ge;
        restart();
        meteor_passed = 1'b1; repeat (4) tick(); meteor_passed = 1'b0;
        n_cmp++; if (score !== 16'd4) begin n_err++; $display("FAIL lvl_score4: got %0d want 4", score); end
        n_cmp++; if (level !== 3'd2) begin n_err++; $display("FAIL lvl_level2: got %0d want 2", level); end
        for (int i = 6; i <= 17; i++) begin
            tick();
            exp_ge = (i == 8) || (i == 16);
            n_cmp++; if (game_enable !== exp_ge) begin n_err++; $display("FAIL period8_c%0d: got %b want %b", i, game_enable, exp_ge); end
        end
        meteor_passed = 1'b1; repeat (6) tick(); meteor_passed = 1'b0;
        n_cmp++; if (score !== 16'd10) begin n_err++; $display("FAIL lvl_score10: got %0d want 10", score); end
        n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL lvl_sat3: got %0d want 3", level); end
        n_cmp++; if (game_enable !== 1'b1) begin n_err++; $display("FAIL lvl_midfire: got %b want 1", game_enable); end
        for (int i = 24; i <= 37; i++) begin
            tick();
            exp_ge = (i == 30) || (i == 37);
            n_cmp++; if (game_enable !== exp_ge) begin n_err++; $display("FAIL period7_c%0d: got %b want %b", i, game_enable, exp_ge); end
        end
    endtask

    task automatic test_pause();
        logic exp_ge;
        restart();
        repeat (4) tick();
        pause_btn = 1'b1; tick();
        n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL pause_enter: got %0d want 2", state); end
        pause_btn = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            n_cmp++; if ({state, game_enable} !== {2'd2, 1'b0}) begin n_err++; $display("FAIL paused_c%0d: got state %0d ge %b want 2/0", i, state, game_enable); end
        end
        pause_btn = 1'b1; tick();
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL pause_resume: got %0d want 1", state); end
        pause_btn = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            exp_ge = (i == 5);
            n_cmp++; if (game_enable !== exp_ge) begin n_err++; $display("FAIL resume_c%0d: got %b want %b", i, game_enable, exp_ge); end
        end
    endtask

    task automatic test_lives();
        restart();
`ifdef GAME_SEQUENCER_LIVES_EN
        meteor_passed = 1'b1; tick(); meteor_passed = 1'b0;
        hit = 1'b1; tick();
        n_cmp++; if (lives !== 2'd2) begin n_err++; $display("FAIL hit1_lives: got %0d want 2", lives); end
        n_cmp++; if (clear_meteors !== 1'b1) begin n_err++; $display("FAIL hit1_clr: got %b want 1", clear_meteors); end
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL hit1_state: got %0d want 1", state); end
        hit = 1'b0; tick();
        n_cmp++; if (clear_meteors !== 1'b0) begin n_err++; $display("FAIL hit1_clr_end: got %b want 0", clear_meteors); end
        hit = 1'b1; tick(); hit = 1'b0; tick();
        n_cmp++; if (lives !== 2'd1) begin n_err++; $display("FAIL hit2_lives: got %0d want 1", lives); end
        hit = 1'b1; tick(); hit = 1'b0;
        n_cmp++; if ({state, lives} !== {2'd3, 2'd0}) begin n_err++; $display("FAIL hit3_over: got state %0d lives %0d want 3/0", state, lives); end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++; if (game_enable !== 1'b0) begin n_err++; $display("FAIL over_ge_c%0d: got %b want 0", i, game_enable); end
        end
        n_cmp++; if (score !== 16'd1) begin n_err++; $display("FAIL over_score: got %0d want 1", score); end
        start_btn = 1'b1; tick(); start_btn = 1'b0;
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL over_to_idle: got %0d want 0", state); end
        tick(); start_btn = 1'b1; tick(); start_btn = 1'b0;
        n_cmp++; if ({state, lives} !== {2'd1, 2'd3}) begin n_err++; $display("FAIL restart_lives: got state %0d lives %0d want 1/3", state, lives); end
        n_cmp++; if (score !== 16'd0) begin n_err++; $display("FAIL restart_score: got %0d want 0", score); end
`else
        hit = 1'b1; tick(); hit = 1'b0;
        n_cmp++; if ({state, lives} !== {2'd3, 2'd0}) begin n_err++; $display("FAIL hit_over: got state %0d lives %0d want 3/0", state, lives); end
        n_cmp++; if (clear_meteors !== 1'b0) begin n_err++; $display("FAIL hit_over_clr: got %b want 0", clear_meteors); end
        start_btn = 1'b1; tick(); start_btn = 1'b0;
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL over_to_idle: got %0d want 0", state); end
        tick(); start_btn = 1'b1; tick(); start_btn = 1'b0;
        n_cmp++; if ({state, clear_meteors} !== {2'd1, 1'b1}) begin n_err++; $display("FAIL restart_run: got state %0d clr %b want 1/1", state, clear_meteors); end
`endif
        tick();
    endtask

    task automatic test_hit_pass();
        restart();
        meteor_passed = 1'b1; tick(); meteor_passed = 1'b0;
`ifdef GAME_SEQUENCER_LIVES_EN
        repeat (2) begin
            hit = 1'b1; tick(); hit = 1'b0; tick();
        end
`endif
        hit = 1'b1; meteor_passed = 1'b1; tick(); hit = 1'b0; meteor_passed = 1'b0;
        n_cmp++; if (score !== 16'd2) begin n_err++; $display("FAIL hitpass_score: got %0d want 2", score); end
        n_cmp++; if ({state, game_enable} !== {2'd3, 1'b0}) begin n_err++; $display("FAIL hitpass_over: got state %0d ge %b want 3/0", state, game_enable); end
        for (int i = 0; i < 25; i++) begin
            tick();
            n_cmp++; if (game_enable !== 1'b0) begin n_err++; $display("FAIL hitpass_ge_c%0d: got %b want 0", i, game_enable); end
        end
        meteor_passed = 1'b1; tick(); meteor_passed = 1'b0; tick();
        n_cmp++; if (score !== 16'd2) begin n_err++; $display("FAIL over_pass_ignored: got %0d want 2", score); end
        pause_btn = 1'b1; tick(); pause_btn = 1'b0; tick();
        n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL over_pause_ignored: got %0d want 3", state); end
    endtask

    task automatic test_hit_on_tick();
        logic exp_ge;
        restart();
        repeat (8) tick();
        hit = 1'b1; tick(); hit = 1'b0;
        n_cmp++; if (game_enable !== 1'b0) begin n_err++; $display("FAIL hittick_ge: got %b want 0", game_enable); end
`ifdef GAME_SEQUENCER_LIVES_EN
        n_cmp++; if ({state, clear_meteors} !== {2'd1, 1'b1}) begin n_err++; $display("FAIL hittick_clr: got state %0d clr %b want 1/1", state, clear_meteors); end
        for (int i = 11; i <= 20; i++) begin
            tick();
            exp_ge = (i == 20);
            n_cmp++; if (game_enable !== exp_ge) begin n_err++; $display("FAIL hittick_c%0d: got %b want %b", i, game_enable, exp_ge); end
        end
`else
        n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL hittick_over: got %0d want 3", state); end
        for (int i = 11; i <= 20; i++) begin
            tick();
            exp_ge = 1'b0;
            n_cmp++; if (game_enable !== exp_ge) begin n_err++; $display("FAIL hittick_c%0d: got %b want %b", i, game_enable, exp_ge); end
        end
`endif
    endtask

    task automatic test_hit_pause();
        logic [1:0] exp_state;
`ifdef GAME_SEQUENCER_LIVES_EN
        exp_state = 2'd1;
`else
        exp_state = 2'd3;
`endif
        restart();
        hit = 1'b1; pause_btn = 1'b1; tick(); hit = 1'b0;
        n_cmp++; if (state !== exp_state) begin n_err++; $display("FAIL hitpause_state: got %0d want %0d", state, exp_state); end
        tick(); pause_btn = 1'b0; tick();
        n_cmp++; if (state !== exp_state) begin n_err++; $display("FAIL hitpause_held: got %0d want %0d", state, exp_state); end
    endtask

    task automatic test_held_start_reset();
        int n_clear;
        reset = 1'b1; tick(); reset = 1'b0; tick();
        n_clear = 0;
        start_btn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (clear_meteors === 1'b1) n_clear++;
        end
        start_btn = 1'b0;
        n_cmp++; if (n_clear !== 1) begin n_err++; $display("FAIL held_start_entries: got %0d want 1", n_clear); end
        n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL held_start_state: got %0d want 1", state); end
        meteor_passed = 1'b1; repeat (3) tick(); meteor_passed = 1'b0;
        n_cmp++; if ({score, level} !== {16'd3, 3'd1}) begin n_err++; $display("FAIL prereset_score: got %0d/%0d want 3/1", score, level); end
        reset = 1'b1; tick();
        n_cmp++; if ({state, game_enable, clear_meteors, score, level, lives} !== {2'd0, 1'b0, 1'b0, 16'd0, 3'd0, RstLives})
            begin n_err++; $display("FAIL midrun_reset: got st %0d ge %b clr %b sc %0d lv %0d li %0d", state, game_enable, clear_meteors, score, level, lives); end
        reset = 1'b0; tick();
        n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL post_reset_idle: got %0d want 0", state); end
    endtask

    initial begin
        test_reset();
        test_start_ticks();
        test_levels();
        test_pause();
        test_lives();
        test_hit_pass();
        test_hit_on_tick();
        test_hit_pause();
        test_held_start_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
